// File: rtl/inorder_iq.sv
`default_nettype none
// ============================================================================
// Module   : inorder_iq
// Purpose  : In-order issue queue. Multi-lane dispatch into a circular
//            buffer, CDB operand capture (stored and same-cycle dispatch),
//            head-only issue with CDB bypass onto the issue payload.
// Revision : 1.0 - initial release
// ============================================================================
module inorder_iq #(
  parameter int IQ_SIZE    = 8,
  parameter int DISP_WIDTH = 2,
  parameter int REG_COUNT  = 2,
  parameter int CDB_COUNT  = 2,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 6,
  parameter int INFO_W     = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic [DISP_WIDTH-1:0]                 disp_valid_i,
  input  logic [DISP_WIDTH*INFO_W-1:0]          disp_info_i,
  input  logic [DISP_WIDTH*REG_COUNT*DATA_W-1:0] disp_data_i,
  input  logic [DISP_WIDTH*REG_COUNT*TAG_W-1:0] disp_tag_i,
  input  logic [DISP_WIDTH*REG_COUNT-1:0]       disp_opv_i,
  output logic                                  disp_ready_o,
  input  logic [CDB_COUNT-1:0]                  cdb_valid_i,
  input  logic [CDB_COUNT*TAG_W-1:0]            cdb_tag_i,
  input  logic [CDB_COUNT*DATA_W-1:0]           cdb_data_i,
  output logic                                  issue_valid_o,
  input  logic                                  issue_ready_i,
  output logic [INFO_W-1:0]                     issue_info_o,
  output logic [REG_COUNT*DATA_W-1:0]           issue_data_o,
  output logic [$clog2(IQ_SIZE):0]              count_o
);

  localparam int PTR_W = $clog2(IQ_SIZE);
  localparam int CNT_W = PTR_W + 1;

  // Entry storage
  logic [INFO_W-1:0]    info_mem [IQ_SIZE];
  logic [DATA_W-1:0]    data_mem [IQ_SIZE][REG_COUNT];
  logic [TAG_W-1:0]     tag_mem  [IQ_SIZE][REG_COUNT];
  logic [REG_COUNT-1:0] opv_mem  [IQ_SIZE];
  logic [IQ_SIZE-1:0]   occ;
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_W-1:0]     count;

  // CDB lookup results: MSB = hit, low bits = captured data
  logic [DATA_W:0]      ent_match  [IQ_SIZE][REG_COUNT];
  logic [DATA_W:0]      lane_match [DISP_WIDTH][REG_COUNT];
  logic [PTR_W-1:0]     lane_slot  [DISP_WIDTH];
  logic [CNT_W-1:0]     acc_cnt;
  logic                 disp_ready;
  logic                 head_ready;
  logic                 do_pop;

  // Search all CDB ports for a tag; the lowest matching port index wins
  function automatic logic [DATA_W:0] cdb_match(
    input logic [TAG_W-1:0]            tag,
    input logic [CDB_COUNT-1:0]        cv,
    input logic [CDB_COUNT*TAG_W-1:0]  ct,
    input logic [CDB_COUNT*DATA_W-1:0] cd
  );
    logic [DATA_W:0] res;
    res = '0;
    for (int c = CDB_COUNT - 1; c >= 0; c--) begin
      if (cv[c] && (ct[c*TAG_W +: TAG_W] == tag)) begin
        res = {1'b1, cd[c*DATA_W +: DATA_W]};
      end
    end
    return res;
  endfunction

  // Admission depends only on the registered occupancy
  assign disp_ready   = (count <= CNT_W'(IQ_SIZE - DISP_WIDTH));
  assign disp_ready_o = disp_ready;
  assign count_o      = count;

  // CDB match for every stored operand and every dispatching operand
  always_comb begin
    for (int e = 0; e < IQ_SIZE; e++) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        ent_match[e][r] = cdb_match(tag_mem[e][r], cdb_valid_i, cdb_tag_i, cdb_data_i);
      end
    end
    for (int l = 0; l < DISP_WIDTH; l++) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        lane_match[l][r] = cdb_match(disp_tag_i[(l*REG_COUNT+r)*TAG_W +: TAG_W],
                                     cdb_valid_i, cdb_tag_i, cdb_data_i);
      end
    end
  end

  // Compact valid lanes onto consecutive slots from tail
  always_comb begin
    acc_cnt = '0;
    for (int l = 0; l < DISP_WIDTH; l++) begin
      lane_slot[l] = tail + acc_cnt[PTR_W-1:0];
      if (disp_valid_i[l]) begin
        acc_cnt = acc_cnt + CNT_W'(1);
      end
    end
    if (!disp_ready) begin
      acc_cnt = '0;
    end
  end

  // Head readiness and issue payload with same-cycle CDB bypass
  always_comb begin
    head_ready   = occ[head];
    issue_data_o = '0;
    for (int r = 0; r < REG_COUNT; r++) begin
      if (!opv_mem[head][r] && !ent_match[head][r][DATA_W]) begin
        head_ready = 1'b0;
      end
      issue_data_o[r*DATA_W +: DATA_W] = opv_mem[head][r] ? data_mem[head][r]
                                                          : ent_match[head][r][DATA_W-1:0];
    end
  end

  assign issue_valid_o = head_ready;
  assign issue_info_o  = info_mem[head];
  assign do_pop        = head_ready & issue_ready_i;

  // Queue state: reset/flush clear, operand capture, pop, dispatch
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      occ   <= '0;
      for (int e = 0; e < IQ_SIZE; e++) begin
        opv_mem[e] <= '0;
      end
    end else begin
      for (int e = 0; e < IQ_SIZE; e++) begin
        for (int r = 0; r < REG_COUNT; r++) begin
          if (occ[e] && !opv_mem[e][r] && ent_match[e][r][DATA_W]) begin
            data_mem[e][r]   <= ent_match[e][r][DATA_W-1:0];
            opv_mem[e][r]    <= 1'b1;
          end
        end
      end
      if (do_pop) begin
        occ[head] <= 1'b0;
        head      <= head + PTR_W'(1);
      end
      if (disp_ready) begin
        for (int l = 0; l < DISP_WIDTH; l++) begin
          if (disp_valid_i[l]) begin
            occ[lane_slot[l]]      <= 1'b1;
            info_mem[lane_slot[l]] <= disp_info_i[l*INFO_W +: INFO_W];
            for (int r = 0; r < REG_COUNT; r++) begin
              tag_mem[lane_slot[l]][r] <= disp_tag_i[(l*REG_COUNT+r)*TAG_W +: TAG_W];
              if (!disp_opv_i[l*REG_COUNT+r] && lane_match[l][r][DATA_W]) begin
                data_mem[lane_slot[l]][r] <= lane_match[l][r][DATA_W-1:0];
                opv_mem[lane_slot[l]][r]  <= 1'b1;
              end else begin
                data_mem[lane_slot[l]][r] <= disp_data_i[(l*REG_COUNT+r)*DATA_W +: DATA_W];
                opv_mem[lane_slot[l]][r]  <= disp_opv_i[l*REG_COUNT+r];
              end
            end
          end
        end
      end
      tail  <= tail + acc_cnt[PTR_W-1:0];
      count <= count + acc_cnt - CNT_W'(do_pop);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inorder_iq.sv
`default_nettype none
// ============================================================================
// Module   : tb_inorder_iq
// Purpose  : Directed self-checking bench for inorder_iq (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_inorder_iq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic [1:0]   disp_valid_i = '0;
  logic [127:0] disp_info_i = '0;
  logic [127:0] disp_data_i = '0;
  logic [23:0]  disp_tag_i = '0;
  logic [3:0]   disp_opv_i = '0;
  logic         disp_ready_o;
  logic [1:0]   cdb_valid_i = '0;
  logic [11:0]  cdb_tag_i = '0;
  logic [63:0]  cdb_data_i = '0;
  logic         issue_valid_o;
  logic         issue_ready_i = 1'b0;
  logic [63:0]  issue_info_o;
  logic [63:0]  issue_data_o;
  logic [3:0]   count_o;

  int tests = 0;
  int failed = 0;

  inorder_iq dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid_i(disp_valid_i), .disp_info_i(disp_info_i),
    .disp_data_i(disp_data_i), .disp_tag_i(disp_tag_i),
    .disp_opv_i(disp_opv_i), .disp_ready_o(disp_ready_o),
    .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_info_o(issue_info_o), .issue_data_o(issue_data_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic clear_in();
    disp_valid_i = '0;
    disp_opv_i   = '0;
    cdb_valid_i  = '0;
  endtask

  task automatic set_lane(input int l, input logic [63:0] info,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [5:0] t0, input logic [5:0] t1,
                          input logic [1:0] opv);
    disp_valid_i[l]             = 1'b1;
    disp_info_i[l*64 +: 64]     = info;
    disp_data_i[l*64 +: 32]     = d0;
    disp_data_i[l*64+32 +: 32]  = d1;
    disp_tag_i[l*12 +: 6]       = t0;
    disp_tag_i[l*12+6 +: 6]     = t1;
    disp_opv_i[l*2 +: 2]        = opv;
  endtask

  // Entry k: info k, op0 = k, op1 = k + 100, both valid
  task automatic put(input int l, input int k);
    set_lane(l, 64'(k), 32'(k), 32'(k + 100), 6'd0, 6'd0, 2'b11);
  endtask

  task automatic set_cdb(input int c, input logic [5:0] tag, input logic [31:0] data);
    cdb_valid_i[c]        = 1'b1;
    cdb_tag_i[c*6 +: 6]   = tag;
    cdb_data_i[c*32 +: 32] = data;
  endtask

  initial begin
    // ---------------- reset ----------------
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_issue_valid", 64'(issue_valid_o), 64'd0);
    chk("rst_disp_ready", 64'(disp_ready_o), 64'd1);

    // ---------------- two-lane dispatch, in-order issue ----------------
    set_lane(0, 64'h1111, 32'h10, 32'h11, 6'd0, 6'd0, 2'b11);
    set_lane(1, 64'h2222, 32'h20, 32'h21, 6'd0, 6'd0, 2'b11);
    #1;
    chk("empty_no_issue", 64'(issue_valid_o), 64'd0);
    step();
    clear_in();
    chk("t1_count2", 64'(count_o), 64'd2);
    chk("t1_valid", 64'(issue_valid_o), 64'd1);
    chk("t1_info0", issue_info_o, 64'h1111);
    chk("t1_data0", issue_data_o, {32'h11, 32'h10});
    issue_ready_i = 1'b1;
    step();
    chk("t1_count1", 64'(count_o), 64'd1);
    chk("t1_info1", issue_info_o, 64'h2222);
    chk("t1_data1", issue_data_o, {32'h21, 32'h20});
    step();
    issue_ready_i = 1'b0;
    chk("t1_count0", 64'(count_o), 64'd0);
    chk("t1_empty", 64'(issue_valid_o), 64'd0);

    // ---------------- lane1-only dispatch after reset ----------------
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_lane(0, 64'hBAD, 32'h0, 32'h0, 6'd0, 6'd0, 2'b11);
    disp_valid_i = 2'b10;
    set_lane(1, 64'h3333, 32'h30, 32'h31, 6'd0, 6'd0, 2'b11);
    step();
    clear_in();
    chk("t2_count", 64'(count_o), 64'd1);
    chk("t2_info", issue_info_o, 64'h3333);
    chk("t2_data", issue_data_o, {32'h31, 32'h30});
    issue_ready_i = 1'b1;
    step();
    issue_ready_i = 1'b0;
    chk("t2_drained", 64'(count_o), 64'd0);

    // ---------------- CDB bypass on head ----------------
    set_lane(0, 64'h4444, 32'h0, 32'h41, 6'd5, 6'd0, 2'b10);
    set_lane(1, 64'h5555, 32'h0, 32'h51, 6'd7, 6'd0, 2'b10);
    step();
    clear_in();
    chk("t3_wait", 64'(issue_valid_o), 64'd0);
    chk("t3_count", 64'(count_o), 64'd2);
    issue_ready_i = 1'b1;
    set_cdb(0, 6'd9, 32'h12345678);
    set_cdb(1, 6'd5, 32'hDEADBEEF);
    #1;
    chk("t3_bypass_valid", 64'(issue_valid_o), 64'd1);
    chk("t3_bypass_info", issue_info_o, 64'h4444);
    chk("t3_bypass_data", issue_data_o, {32'h41, 32'hDEADBEEF});
    step();
    clear_in();
    issue_ready_i = 1'b0;
    chk("t3_count1", 64'(count_o), 64'd1);
    chk("t3_behind_waits", 64'(issue_valid_o), 64'd0);
    set_cdb(0, 6'd7, 32'hAAAA);
    set_cdb(1, 6'd7, 32'hBBBB);
    #1;
    chk("t3_lowest_cdb", issue_data_o, {32'h51, 32'hAAAA});
    step();
    clear_in();
    chk("t3_captured_valid", 64'(issue_valid_o), 64'd1);
    chk("t3_captured_data", issue_data_o, {32'h51, 32'hAAAA});
    issue_ready_i = 1'b1;
    step();
    issue_ready_i = 1'b0;
    chk("t3_drained", 64'(count_o), 64'd0);

    // ---------------- fill, full, simultaneous pop+dispatch, wrap ----------------
    for (int c = 0; c < 3; c++) begin
      put(0, 2*c + 1);
      put(1, 2*c + 2);
      step();
      clear_in();
      chk("t4_fill_count", 64'(count_o), 64'(2*c + 2));
      chk("t4_fill_ready", 64'(disp_ready_o), 64'd1);
    end
    put(0, 7);
    put(1, 8);
    step();
    clear_in();
    chk("t4_full_count", 64'(count_o), 64'd8);
    chk("t4_full_ready", 64'(disp_ready_o), 64'd0);
    put(0, 11);
    put(1, 12);
    step();
    clear_in();
    chk("t4_ignored_disp", 64'(count_o), 64'd8);
    issue_ready_i = 1'b1;
    chk("t4_head1", issue_info_o, 64'd1);
    step();
    chk("t4_count7", 64'(count_o), 64'd7);
    chk("t4_ready7", 64'(disp_ready_o), 64'd0);
    chk("t4_head2", issue_info_o, 64'd2);
    step();
    chk("t4_count6", 64'(count_o), 64'd6);
    chk("t4_ready6", 64'(disp_ready_o), 64'd1);
    chk("t4_head3", issue_info_o, 64'd3);
    set_lane(0, 64'd9, 32'h0, 32'd109, 6'd3, 6'd0, 2'b10);
    put(1, 10);
    set_cdb(0, 6'd3, 32'h99);
    step();
    clear_in();
    chk("t4_pop_disp_count", 64'(count_o), 64'd7);
    for (int k = 4; k <= 10; k++) begin
      chk("t4_order_valid", 64'(issue_valid_o), 64'd1);
      chk("t4_order_info", issue_info_o, 64'(k));
      chk("t4_order_data", issue_data_o,
          {32'(k + 100), (k == 9) ? 32'h99 : 32'(k)});
      step();
    end
    issue_ready_i = 1'b0;
    chk("t4_drained", 64'(count_o), 64'd0);

    // ---------------- stall holds payload ----------------
    set_lane(0, 64'hC0FFEE, 32'h5, 32'h6, 6'd0, 6'd0, 2'b11);
    step();
    clear_in();
    for (int c = 0; c < 3; c++) begin
      chk("t5_hold_valid", 64'(issue_valid_o), 64'd1);
      chk("t5_hold_info", issue_info_o, 64'hC0FFEE);
      chk("t5_hold_data", issue_data_o, {32'h6, 32'h5});
      chk("t5_hold_count", 64'(count_o), 64'd1);
      step();
    end
    issue_ready_i = 1'b1;
    step();
    issue_ready_i = 1'b0;
    chk("t5_popped", 64'(count_o), 64'd0);

    // ---------------- flush with concurrent dispatch ----------------
    put(0, 20);
    put(1, 21);
    step();
    put(0, 22);
    put(1, 23);
    step();
    clear_in();
    put(0, 24);
    step();
    clear_in();
    chk("t6_count5", 64'(count_o), 64'd5);
    flush = 1'b1;
    put(0, 30);
    put(1, 31);
    issue_ready_i = 1'b1;
    step();
    flush = 1'b0;
    issue_ready_i = 1'b0;
    clear_in();
    chk("t6_flush_count", 64'(count_o), 64'd0);
    chk("t6_flush_valid", 64'(issue_valid_o), 64'd0);
    chk("t6_flush_ready", 64'(disp_ready_o), 64'd1);
    set_lane(1, 64'hF00D, 32'h1, 32'h2, 6'd0, 6'd0, 2'b11);
    step();
    clear_in();
    chk("t6_after_count", 64'(count_o), 64'd1);
    chk("t6_after_info", issue_info_o, 64'hF00D);
    issue_ready_i = 1'b1;
    step();
    issue_ready_i = 1'b0;

    // ---------------- reset mid-operation ----------------
    put(0, 50);
    put(1, 51);
    step();
    clear_in();
    chk("t7_count2", 64'(count_o), 64'd2);
    rst = 1'b1;
    flush = 1'b1;
    put(0, 52);
    step();
    rst = 1'b0;
    flush = 1'b0;
    clear_in();
    chk("t7_rst_count", 64'(count_o), 64'd0);
    chk("t7_rst_valid", 64'(issue_valid_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
